// File: rtl/regs_multi_if.sv
// Register file access bundle: NRD read lanes, one write port, clear-sweep busy.
// Master drives addresses/enables/write data; slave returns read data and busy.
interface regs_multi_if #(
    parameter int DW  = 32,
    parameter int AW  = 4,
    parameter int NRD = 2
);
    logic [NRD*AW-1:0] rd_reg;
    logic [NRD-1:0]    rd_en;
    logic [NRD*DW-1:0] rd_data;
    logic [AW-1:0]     wr_reg;
    logic [DW-1:0]     wr_data;
    logic              wr_en;
    logic              busy;

    modport master (
        output rd_reg, rd_en, wr_reg, wr_data, wr_en,
        input  rd_data, busy
    );

    modport slave (
        input  rd_reg, rd_en, wr_reg, wr_data, wr_en,
        output rd_data, busy
    );
endinterface

// File: rtl/regs_multi.sv
// Multi-read-port register file: NRD replicated banks, broadcast write, clear sweep.
// Optional REGS_BYPASS_EN forwards same-edge write data to matching read lanes.
module regs_multi #(
    parameter int            DW      = 32,
    parameter int            AW      = 4,
    parameter int            NRD     = 2,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic        clk,
    input  logic        rst,
    regs_multi_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic          busy_q, busy_nx;
    logic          we;
    logic          run;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            busy_q <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy_nx  = busy_q;
        we       = 1'b0;
        run      = 1'b0;
        waddr    = bus.wr_reg;
        wdata    = bus.wr_data;
        unique case (state)
            CLEAR: begin
                we     = 1'b1;
                waddr  = cnt;
                wdata  = CLR_VAL;
                cnt_nx = cnt + 1'b1;
                if (&cnt) begin
                    state_nx = RUN;
                    busy_nx  = 1'b0;
                end
            end
            RUN: begin
                run = 1'b1;
                we  = bus.wr_en;
            end
        endcase
    end

    assign bus.busy = busy_q;

    // One bank per read port; every bank sees the same write.
    for (genvar g = 0; g < NRD; g++) begin : g_bank
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] q;
        logic [AW-1:0] ra;

        assign ra = bus.rd_reg[g*AW +: AW];

        always_ff @(posedge clk) begin
            if (we && !rst)
                mem[waddr] <= wdata;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else if (run && bus.rd_en[g]) begin
`ifdef REGS_BYPASS_EN
                if (bus.wr_en && ra == bus.wr_reg)
                    q <= bus.wr_data;
                else
                    q <= mem[ra];
`else
                q <= mem[ra];
`endif
            end
        end

        assign bus.rd_data[g*DW +: DW] = q;
    end
endmodule

// File: tb/tb_regs_multi.sv
// Bench for regs_multi: 2-port and 3-port instances against an array model.
module tb_regs_multi;
    localparam int DEPTH = 16;
    localparam logic [31:0] CLR2 = 32'hDEADBEEF;
    localparam logic [31:0] CLR3 = 32'h0;
`ifdef REGS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regs_multi_if #(.DW(32), .AW(4), .NRD(2)) b2 ();
    regs_multi_if #(.DW(32), .AW(4), .NRD(3)) b3 ();

    regs_multi #(.DW(32), .AW(4), .NRD(2), .CLR_VAL(CLR2)) u2 (
        .clk(clk), .rst(rst), .bus(b2)
    );
    regs_multi #(.DW(32), .AW(4), .NRD(3), .CLR_VAL(CLR3)) u3 (
        .clk(clk), .rst(rst), .bus(b3)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference: word arrays, expected lane contents, and remaining sweep cycles.
    logic [31:0] mdl2 [DEPTH];
    logic [31:0] mdl3 [DEPTH];
    logic [31:0] e2 [2];
    logic [31:0] e3 [3];
    int          clr_left = 0;
    logic [3:0]  ma;

    always @(posedge clk) begin
        if (rst) begin
            clr_left = DEPTH;
            foreach (e2[p]) e2[p] = '0;
            foreach (e3[p]) e3[p] = '0;
        end else if (clr_left > 0) begin
            mdl2[DEPTH-clr_left] = CLR2;
            mdl3[DEPTH-clr_left] = CLR3;
            clr_left--;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (b2.rd_en[p]) begin
                    ma = b2.rd_reg[p*4 +: 4];
                    e2[p] = (BYP && b2.wr_en && ma == b2.wr_reg) ? b2.wr_data : mdl2[ma];
                end
            end
            for (int p = 0; p < 3; p++) begin
                if (b3.rd_en[p]) begin
                    ma = b3.rd_reg[p*4 +: 4];
                    e3[p] = (BYP && b3.wr_en && ma == b3.wr_reg) ? b3.wr_data : mdl3[ma];
                end
            end
            if (b2.wr_en) mdl2[b2.wr_reg] = b2.wr_data;
            if (b3.wr_en) mdl3[b3.wr_reg] = b3.wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b2.rd_en = '0; b2.wr_en = 1'b0; b2.rd_reg = '0; b2.wr_reg = '0; b2.wr_data = '0;
        b3.rd_en = '0; b3.wr_en = 1'b0; b3.rd_reg = '0; b3.wr_reg = '0; b3.wr_data = '0;
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst = 1'b1;
        repeat (3) tick();
        nvec++;
        if (b2.busy !== 1'b1 || b2.rd_data !== 64'h0) begin
            nerr++;
            $display("FAIL reset_state busy=%b data=%h need busy=1 data=0", b2.busy, b2.rd_data);
        end
        rst = 1'b0;
        n = 1;
        while (b2.busy === 1'b1 && n < 40) begin
            tick();
            nvec++;
            if (b2.rd_data !== 64'h0 || b2.busy !== (clr_left > 0)) begin
                nerr++;
                $display("FAIL sweep_cycle%0d busy=%b data=%h need busy=%b data=0",
                         n, b2.busy, b2.rd_data, clr_left > 0);
            end
            if (b2.busy === 1'b1) n++;
        end
        nvec++;
        if (n !== 16) begin
            nerr++;
            $display("FAIL busy_length got %0d cycles need 16", n);
        end
        for (int i = 0; i < DEPTH; i++) begin
            b2.rd_en = 2'b11;
            b2.rd_reg = {4'(15 - i), 4'(i)};
            tick();
            nvec++;
            if (b2.rd_data !== {CLR2, CLR2}) begin
                nerr++;
                $display("FAIL clr_read%0d got %h need %h", i, b2.rd_data, {CLR2, CLR2});
            end
        end
        idle();
    endtask

    task automatic test_basic();
        b2.wr_en = 1'b1; b2.wr_reg = 4'd5; b2.wr_data = 32'h12345678;
        tick();
        b2.wr_reg = 4'd9; b2.wr_data = 32'hCAFEF00D;
        tick();
        b2.wr_en = 1'b0; b2.rd_en = 2'b11; b2.rd_reg = {4'd9, 4'd5};
        tick();
        nvec++;
        if (b2.rd_data !== {32'hCAFEF00D, 32'h12345678}) begin
            nerr++;
            $display("FAIL basic_rw got %h need cafef00d12345678", b2.rd_data);
        end
    endtask

    task automatic test_rd_en_hold();
        b2.rd_en = 2'b00; b2.rd_reg = {4'd9, 4'd9};
        b2.wr_en = 1'b1; b2.wr_reg = 4'd5; b2.wr_data = 32'h0;
        tick();
        b2.wr_en = 1'b0;
        repeat (2) begin
            tick();
            nvec++;
            if (b2.rd_data[31:0] !== 32'h12345678) begin
                nerr++;
                $display("FAIL rd_en_hold got %h need 12345678", b2.rd_data[31:0]);
            end
        end
        b2.rd_en = 2'b01; b2.rd_reg = {4'd9, 4'd5};
        tick();
        nvec++;
        if (b2.rd_data[31:0] !== 32'h0) begin
            nerr++;
            $display("FAIL rd_en_reload got %h need 0", b2.rd_data[31:0]);
        end
        idle();
    endtask

    task automatic test_rdw();
        logic [31:0] need;
        need = BYP ? 32'h22 : 32'h11;
        b2.wr_en = 1'b1; b2.wr_reg = 4'd3; b2.wr_data = 32'h11;
        tick();
        b2.wr_data = 32'h22; b2.rd_en = 2'b10; b2.rd_reg = {4'd3, 4'd0};
        tick();
        nvec++;
        if (b2.rd_data[63:32] !== need) begin
            nerr++;
            $display("FAIL rdw_same got %h need %h", b2.rd_data[63:32], need);
        end
        b2.wr_en = 1'b0;
        tick();
        nvec++;
        if (b2.rd_data[63:32] !== 32'h22) begin
            nerr++;
            $display("FAIL rdw_after got %h need 00000022", b2.rd_data[63:32]);
        end
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            b2.wr_en = 1'($urandom); b2.wr_reg = 4'($urandom); b2.wr_data = $urandom;
            b2.rd_en = 2'($urandom); b2.rd_reg = 8'($urandom);
            b3.wr_en = 1'($urandom); b3.wr_reg = 4'($urandom); b3.wr_data = $urandom;
            b3.rd_en = 3'($urandom); b3.rd_reg = 12'($urandom);
            if (c % 7 == 0) b2.rd_reg = {b2.wr_reg, b2.wr_reg};
            tick();
            for (int p = 0; p < 2; p++) begin
                nvec++;
                if (b2.rd_data[p*32 +: 32] !== e2[p]) begin
                    nerr++;
                    $display("FAIL rand2 c%0d lane%0d got %h need %h",
                             c, p, b2.rd_data[p*32 +: 32], e2[p]);
                end
            end
            for (int p = 0; p < 3; p++) begin
                nvec++;
                if (b3.rd_data[p*32 +: 32] !== e3[p]) begin
                    nerr++;
                    $display("FAIL rand3 c%0d lane%0d got %h need %h",
                             c, p, b3.rd_data[p*32 +: 32], e3[p]);
                end
            end
        end
        idle();
    endtask

    task automatic test_midsweep();
        int n;
        b2.rd_en = 2'b11;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b2.wr_en = 1'b1; b2.wr_reg = 4'd2; b2.wr_data = 32'hFFFFFFFF;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 1;
        while (b2.busy === 1'b1 && n < 40) begin
            tick();
            nvec++;
            if (b2.rd_data !== 64'h0) begin
                nerr++;
                $display("FAIL midsweep_data got %h need 0", b2.rd_data);
            end
            if (b2.busy === 1'b1) n++;
        end
        nvec++;
        if (n !== 16) begin
            nerr++;
            $display("FAIL midsweep_busy got %0d cycles need 16", n);
        end
        b2.wr_en = 1'b0; b2.rd_reg = {4'd2, 4'd2};
        tick();
        nvec++;
        if (b2.rd_data !== {CLR2, CLR2}) begin
            nerr++;
            $display("FAIL midsweep_entry2 got %h need %h", b2.rd_data, {CLR2, CLR2});
        end
        idle();
    endtask

    task automatic test_nrd3();
        b3.wr_en = 1'b1; b3.wr_reg = 4'd15; b3.wr_data = 32'hA5A5A5A5;
        tick();
        b3.wr_en = 1'b0; b3.rd_en = 3'b111; b3.rd_reg = {4'd15, 4'd15, 4'd15};
        tick();
        nvec++;
        if (b3.rd_data !== {3{32'hA5A5A5A5}}) begin
            nerr++;
            $display("FAIL nrd3_same got %h need a5a5a5a5 x3", b3.rd_data);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rd_en_hold();
        test_rdw();
        test_random();
        test_midsweep();
        test_nrd3();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/regs_multi.md
Name: regs_multi

Overview:
- Parametrised successor to the CPU triple-ported register file.
- Register file with DEPTH = 2^AW words of DW bits and NRD synchronous read ports, shared by one write port.
- Built as NRD replicated dual-ported banks with the write broadcast to every bank.
- Adds per-port read enables, a post-reset hardware clear sweep with a busy flag, and optional write-to-read bypass; sits in the CPU datapath between decode and ALU.

Parameters:
- DW, 32, data width in bits
- AW, 4, address width; DEPTH = 2^AW entries
- NRD, 2, number of read ports (>=1)
- CLR_VAL, 0, value written to every entry by the clear sweep (DW bits)

Ports:
- clk  in  1  system clock
- rst  in  1  system reset; synchronous, active-high
- rd_reg  in  NRD*AW  read addresses; port p uses bits [p*AW +: AW]
- rd_en  in  NRD  per-port read enable
- rd_data  out  NRD*DW  registered read data; port p uses bits [p*DW +: DW]
- wr_reg  in  AW  write address
- wr_data  in  DW  write data
- wr_en  in  1  write enable
- busy  out  1  high while the clear sweep runs; writes and reads are not accepted

Behaviour:
- Reset: rst=1 sampled at a rising edge of clk sets state=CLEAR, sweep counter cnt=0, busy=1, and every rd_data lane to 0. Array contents are not touched by rst itself.
- States: CLEAR and RUN.
- CLEAR, each cycle with rst=0:
  - writes CLR_VAL to entry cnt in all NRD banks;
  - cnt increments;
  - when the entry written is DEPTH-1, the next state is RUN and busy falls at that same edge.
  - busy is therefore high for exactly DEPTH cycles after rst deasserts.
  - wr_en, rd_en and addresses are ignored; rd_data holds 0.
- rst asserted mid-sweep restarts the sweep from cnt=0. Entries already cleared stay cleared.
- RUN, write: wr_en=1 writes wr_data to entry wr_reg in all banks at the rising edge.
- RUN, read: latency is 1 cycle. With rd_en[p]=1, lane p is loaded at the edge with bank p [rd_reg lane p]. With rd_en[p]=0, lane p holds its previous value.
- Read-during-write, same address at the same edge: lane p returns the OLD contents (see Optional Feature). Different addresses do not interact.
- Several read ports may use the same address in the same cycle; all return identical data.
- There is no entry hardwired to zero; all DEPTH entries are writable.
- Addresses are always in range by construction (AW bits), so no wrap handling is needed.
- No combinational path exists from any input to rd_data or busy.

Optional Feature:
- Macro: REGS_BYPASS_EN
- Defined: when wr_en=1 in RUN, and for a port with rd_en[p]=1 and rd_reg lane p == wr_reg, lane p is loaded with wr_data instead of the stored word. Read-after-write then needs no stall.
- Not defined: the read returns the old word. The CPU pipeline must interlock for one cycle.
- The macro does not change CLEAR behaviour, busy timing or the port list.

Test Plan:
- Reset sweep: AW=4, CLR_VAL=32'hDEADBEEF. Hold rst for 3 cycles, then release → busy=1 for exactly 16 cycles then 0, and rd_data=0 throughout. Then read all 16 entries on both ports → every read returns 32'hDEADBEEF.
- Basic write/read: write entry 5=32'h12345678 and entry 9=32'hCAFEF00D. Next cycle read port0 addr 5 and port1 addr 9 with rd_en=2'b11 → one cycle later lane0=32'h12345678 and lane1=32'hCAFEF00D.
- Read enable hold: lane0 holds 32'h12345678. Set rd_en[0]=0, change rd_reg lane0 to 9 and write entry 5=0 → lane0 stays 32'h12345678 until rd_en[0]=1.
- Read-during-write: entry 3=32'h00000011. Write entry 3=32'h00000022 while port1 reads addr 3 in the same cycle → lane1=32'h00000011 without REGS_BYPASS_EN, and 32'h00000022 with it. The following read of 3 returns 32'h00000022 in both builds.
- Reset mid-sweep and ignored traffic: assert rst for 1 cycle at cnt=7, and drive wr_en=1 (addr 2, 32'hFFFFFFFF) during the sweep → busy stays high for 16 cycles after the second reset release, and entry 2 reads CLR_VAL afterwards.
- NRD=3 variant: all three ports read addr 15 after writing 32'hA5A5A5A5 there → all lanes return 32'hA5A5A5A5 on the same cycle.
